// File: rtl/lbus_axi_pkg.sv
// Shared types and helpers for the LBUS/AXI receive-path blocks.
package lbus_axi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } guard_state_t;

    localparam int STAT_W     = 32;
    localparam int KEEP_MAX_W = 64;

    // Number of enabled bytes in a keep vector (narrower keeps are zero-extended).
    function automatic logic [6:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + 7'(keep[i]);
        end
        return cnt;
    endfunction

    // True when keep is 2^n-1 with n>=1: low bytes enabled, no holes, not empty.
    function automatic logic keep_is_contiguous(input logic [KEEP_MAX_W-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer. Output comes straight from a register and
// s_ready depends only on local state, so m_ready has no combinational path
// to the upstream side. s_ready stays low until the first edge after reset.
module axis_skid_buffer #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_resetn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_payload
);

    logic                 rdy_en;
    logic                 vld_p0;
    logic                 vld_p1;
    logic [PAYLOAD_W-1:0] payload_p0;
    logic [PAYLOAD_W-1:0] payload_p1;
    logic                 push;
    logic                 pop;
    logic                 load_p1;

    assign s_ready   = rdy_en & ~vld_p1;
    assign push      = s_valid & s_ready;
    assign pop       = vld_p0 & m_ready;
    assign load_p1   = push & ~vld_p1 & vld_p0 & ~pop;
    assign m_valid   = vld_p0;
    assign m_payload = payload_p0;

    // ---- stage p0: output register, refilled from input or from the skid entry
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            rdy_en     <= 1'b0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            payload_p0 <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (vld_p1) begin
                if (pop) begin
                    payload_p0 <= payload_p1;
                    vld_p1     <= 1'b0;
                end
            end else if (push) begin
                if (!vld_p0 || pop) begin
                    payload_p0 <= s_payload;
                    vld_p0     <= 1'b1;
                end else begin
                    vld_p1 <= 1'b1;
                end
            end else if (pop) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    // ---- stage p1: skid entry, only meaningful while vld_p1 is set
    always_ff @(posedge sys_clk) begin
        if (load_p1) begin
            payload_p1 <= s_payload;
        end
    end

endmodule

// File: rtl/axis_rx_pkt_guard.sv
// Receive-path packet framing guard: flags runt, oversize and bad-tkeep packets
// on tuser with the last beat and truncates oversize packets with a forced tlast.
// Build option: define AXIS_RX_PKT_GUARD_STATS_EN to implement the statistics
// counters; otherwise the stat_* ports are tied to zero.
module axis_rx_pkt_guard
    import lbus_axi_pkg::*;
#(
    parameter int M_TDATA_WIDTH = 8,
    parameter int MIN_BYTES     = 64,
    parameter int MAX_BYTES     = 1518,
    parameter int BYTE_CNT_W    = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_resetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [M_TDATA_WIDTH*8-1:0] s_axis_tdata,
    input  logic [M_TDATA_WIDTH-1:0]   s_axis_tkeep,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [M_TDATA_WIDTH*8-1:0] m_axis_tdata,
    output logic [M_TDATA_WIDTH-1:0]   m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic [STAT_W-1:0]          stat_pkt_cnt,
    output logic [STAT_W-1:0]          stat_err_cnt,
    output logic [STAT_W-1:0]          stat_trunc_cnt
);

    localparam int PAYLOAD_W = M_TDATA_WIDTH * 9 + 2;
    localparam logic [BYTE_CNT_W:0]      MAX_LEN   = (BYTE_CNT_W + 1)'(MAX_BYTES);
    localparam logic [BYTE_CNT_W:0]      MIN_LEN   = (BYTE_CNT_W + 1)'(MIN_BYTES);
    localparam logic [M_TDATA_WIDTH-1:0] KEEP_FULL = '1;

    guard_state_t          state;
    guard_state_t          state_nxt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt_nxt;
    logic                  err;
    logic                  err_nxt;
    logic                  accept;
    logic [6:0]            beat_bytes;
    logic [BYTE_CNT_W:0]   sum;
    logic                  beat_fault;
    logic                  err_all;
    logic                  emit;
    logic                  emit_last;
    logic                  emit_user;
    logic                  trunc_evt;
    logic [PAYLOAD_W-1:0]  skid_in;
    logic [PAYLOAD_W-1:0]  skid_out;

    assign accept     = s_axis_tvalid & s_axis_tready;
    assign beat_bytes = keep_popcount(KEEP_MAX_W'(s_axis_tkeep));
    // One extra bit so an oversize running total can never wrap below MAX_LEN.
    assign sum        = {1'b0, byte_cnt} + (BYTE_CNT_W + 1)'(beat_bytes);
    assign beat_fault = s_axis_tlast ? ~keep_is_contiguous(KEEP_MAX_W'(s_axis_tkeep))
                                     : (s_axis_tkeep != KEEP_FULL);
    assign err_all    = err | beat_fault;

    // ---- stage p0 input: framing state, running byte count and sticky error
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state    <= IDLE;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            err      <= err_nxt;
        end
    end

    // Per-beat decision: forward, truncate, close the packet or drop the tail.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        err_nxt      = err;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_user    = 1'b0;
        trunc_evt    = 1'b0;
        if (accept) begin
            case (state)
                IDLE, IN_PKT: begin
                    emit = 1'b1;
                    if (sum > MAX_LEN) begin
                        emit_last    = 1'b1;
                        emit_user    = 1'b1;
                        trunc_evt    = 1'b1;
                        byte_cnt_nxt = '0;
                        err_nxt      = 1'b0;
                        state_nxt    = s_axis_tlast ? IDLE : DISCARD;
                    end else if (s_axis_tlast) begin
                        emit_last    = 1'b1;
                        emit_user    = err_all | (sum < MIN_LEN);
                        byte_cnt_nxt = '0;
                        err_nxt      = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        byte_cnt_nxt = sum[BYTE_CNT_W-1:0];
                        err_nxt      = err_all;
                        state_nxt    = IN_PKT;
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                    err_nxt      = 1'b0;
                end
            endcase
        end
    end

    assign skid_in = {emit_user, emit_last, s_axis_tkeep, s_axis_tdata};

    // ---- stage p0/p1: registered output plus skid entry
    axis_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .s_valid    (emit),
        .s_ready    (s_axis_tready),
        .s_payload  (skid_in),
        .m_valid    (m_axis_tvalid),
        .m_ready    (m_axis_tready),
        .m_payload  (skid_out)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_out;

`ifdef AXIS_RX_PKT_GUARD_STATS_EN
    logic [STAT_W-1:0] pkt_cnt;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] trunc_cnt;
    logic              out_last_hs;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    assign out_last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Saturating statistics: packets/errors on output handshake, truncations on decision.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (out_last_hs) begin
                pkt_cnt <= sat_inc(pkt_cnt);
            end
            if (out_last_hs && m_axis_tuser) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (trunc_evt) begin
                trunc_cnt <= sat_inc(trunc_cnt);
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt;
    assign stat_err_cnt   = err_cnt;
    assign stat_trunc_cnt = trunc_cnt;
`else
    logic unused_stats;
    assign unused_stats   = trunc_evt;
    assign stat_pkt_cnt   = '0;
    assign stat_err_cnt   = '0;
    assign stat_trunc_cnt = '0;
`endif

endmodule
